vec_lsu_sequencer: RTL

//  Sequences one vector load/store into per-element memory requests, one element at a time.

---
 rtl/vec_lsu_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vec_lsu_sequencer.sv
// Vector load/store sequencer: turns one vector memory instruction into per-element requests.
// Optional WAIT_RSP watchdog enabled by defining VEC_LSU_TIMEOUT_EN.
module vec_lsu_sequencer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned VL_W    = 9,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ld_inst,
  input  logic            st_inst,
  input  logic            stride_sel,
  input  logic            index_str,
  input  logic [XLEN-1:0] base_addr,
  input  logic [XLEN-1:0] stride,
  input  logic [1:0]      eew,
  input  logic [VL_W-1:0] vl,
  input  logic [XLEN-1:0] idx_offset,
  output logic [VL_W-1:0] elem_idx,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [1:0]      mem_size,
  input  logic            mem_rsp_valid,
  output logic            vrf_wr_en,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] base_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] step_q;
  logic [VL_W-1:0] vl_q;
  logic            indexed_q;
  logic            load_q;
  logic [1:0]      shift_c;
  logic [XLEN-1:0] idx_addr_c;
  logic            last_c;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("vec_lsu_sequencer: TIMEOUT must be at least 1");
  end

`ifdef VEC_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_comb begin
    shift_c    = (eew == 2'b11) ? 2'd2 : eew;
    idx_addr_c = base_q + idx_offset;
    last_c     = (elem_idx == VL_W'(vl_q - VL_W'(1)));
  end

  // Indexed mode presents base+idx_offset while the VRF drives the index for elem_idx.
  assign mem_addr  = (indexed_q && state == REQ) ? idx_addr_c : addr_q;
  // Writeback strobe coincides with the returning load data.
  assign vrf_wr_en = (state == WAIT_RSP) && mem_rsp_valid && load_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      addr_q        <= '0;
      step_q        <= '0;
      vl_q          <= '0;
      indexed_q     <= 1'b0;
      load_q        <= 1'b0;
      elem_idx      <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_size      <= 2'b00;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
`ifdef VEC_LSU_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            addr_q    <= base_addr;
            step_q    <= stride_sel ? (XLEN'(1) << shift_c) : stride;
            vl_q      <= vl;
            indexed_q <= index_str;
            load_q    <= ld_inst & ~st_inst;
            mem_we    <= st_inst & ~ld_inst;
            mem_size  <= eew;
            elem_idx  <= '0;
            busy      <= 1'b1;
            // Empty or ambiguous instructions complete without touching memory.
            if (vl != '0 && (ld_inst ^ st_inst)) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_RSP;
            if (indexed_q) addr_q <= idx_addr_c;
`ifdef VEC_LSU_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (last_c) begin
              state <= DONE;
            end else begin
              elem_idx      <= elem_idx + VL_W'(1);
              addr_q        <= addr_q + step_q;
              mem_req_valid <= 1'b1;
              state         <= REQ;
            end
          end
`ifdef VEC_LSU_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
